// File: rtl/ps2_mouse_packet_if.sv
// Bundles the PS/2 byte input stream and the decoded mouse packet outputs.
// The byte source (the PS/2 receiver, or a bench) uses the master modport.
// The packet assembler uses the slave modport.
interface ps2_mouse_packet_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       pkt_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic [9:0] cursor_x;
  logic [8:0] cursor_y;
  logic       sync_err;

  modport master (
    output byte_valid, byte_data,
    input  pkt_valid, buttons, dx, dy, cursor_x, cursor_y, sync_err
  );

  modport slave (
    input  byte_valid, byte_data,
    output pkt_valid, buttons, dx, dy, cursor_x, cursor_y, sync_err
  );
endinterface

// File: rtl/ps2_mouse_packet.sv
// Builds 3-byte PS/2 mouse packets from the received byte stream.
// Decodes the buttons and the signed X/Y motion, and keeps a screen-clamped cursor.
// Alignment is recovered in two ways: a header byte must have bit 3 set, and a
// partial packet is dropped when the gap between its bytes grows too long.
module ps2_mouse_packet #(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int TIMEOUT = 200000
) (
  input  logic                  Bus2IP_Clk,
  input  logic                  Bus2IP_Resetn,
  ps2_mouse_packet_if.slave     bus
);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

  localparam logic [17:0]        TO_COUNT = 18'(TIMEOUT);
  localparam logic signed [11:0] X_LIM    = 12'(X_MAX);
  localparam logic signed [11:0] Y_LIM    = 12'(Y_MAX);

  state_t state, state_nxt;
  logic [17:0] tmo_count;
  // The header byte is kept without bit 3, because bit 3 is only the alignment marker.
  // Field order is {y_ovf, x_ovf, y_sign, x_sign, buttons[2:0]}.
  logic [6:0] hdr_q;
  logic [7:0] b1_q;

  logic              timeout_hit;
  logic              pkt_fire;
  logic              sync_fire;
  logic [8:0]        dx_new;
  logic [8:0]        dy_new;
  logic signed [11:0] sum_x;
  logic signed [11:0] sum_y;
  logic [9:0]        cx_new;
  logic [8:0]        cy_new;

  // A byte arriving on the expiry cycle takes priority, so expiry needs an idle cycle.
  assign timeout_hit = (state != WAIT_B0) && !bus.byte_valid && (tmo_count == TO_COUNT);

  // State register
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) state <= WAIT_B0;
    else                state <= state_nxt;
  end

  // Next-state logic: walk through the three bytes, falling back to WAIT_B0 on expiry
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_B0: if (bus.byte_valid && bus.byte_data[3]) state_nxt = WAIT_B1;
      WAIT_B1: begin
        if (bus.byte_valid)   state_nxt = WAIT_B2;
        else if (timeout_hit) state_nxt = WAIT_B0;
      end
      WAIT_B2: begin
        if (bus.byte_valid)   state_nxt = WAIT_B0;
        else if (timeout_hit) state_nxt = WAIT_B0;
      end
      default: state_nxt = WAIT_B0;
    endcase
  end

  // Output logic: decode the packet as the third byte arrives, and compute the clamped cursor
  always_comb begin
    pkt_fire  = (state == WAIT_B2) && bus.byte_valid;
    sync_fire = ((state == WAIT_B0) && bus.byte_valid && !bus.byte_data[3]) || timeout_hit;
    dx_new    = hdr_q[5] ? 9'd0 : {hdr_q[3], b1_q};
    dy_new    = hdr_q[6] ? 9'd0 : {hdr_q[4], bus.byte_data};
    sum_x     = $signed({2'b00, bus.cursor_x}) + $signed({{3{dx_new[8]}}, dx_new});
    sum_y     = $signed({3'b000, bus.cursor_y}) - $signed({{3{dy_new[8]}}, dy_new});
    if (sum_x < 12'sd0)     cx_new = 10'd0;
    else if (sum_x > X_LIM) cx_new = 10'(X_MAX);
    else                    cx_new = sum_x[9:0];
    if (sum_y < 12'sd0)     cy_new = 9'd0;
    else if (sum_y > Y_LIM) cy_new = 9'(Y_MAX);
    else                    cy_new = sum_y[8:0];
  end

  // Inter-byte gap counter: runs only mid-packet and restarts on every accepted byte
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn)                                          tmo_count <= '0;
    else if (state == WAIT_B0 || bus.byte_valid || timeout_hit) tmo_count <= '0;
    else                                                         tmo_count <= tmo_count + 18'd1;
  end

  // Hold the first two bytes until the third one completes the packet
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      hdr_q <= '0;
      b1_q  <= '0;
    end else begin
      if (state == WAIT_B0 && bus.byte_valid && bus.byte_data[3])
        hdr_q <= {bus.byte_data[7:4], bus.byte_data[2:0]};
      if (state == WAIT_B1 && bus.byte_valid)
        b1_q <= bus.byte_data;
    end
  end

  // Registered outputs: the pulses come every cycle, and the packet data only moves on pkt_fire
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      bus.pkt_valid <= 1'b0;
      bus.sync_err  <= 1'b0;
      bus.buttons   <= '0;
      bus.dx        <= '0;
      bus.dy        <= '0;
      bus.cursor_x  <= 10'(X_MAX / 2);
      bus.cursor_y  <= 9'(Y_MAX / 2);
    end else begin
      bus.pkt_valid <= pkt_fire;
      bus.sync_err  <= sync_fire;
      if (pkt_fire) begin
        bus.buttons  <= hdr_q[2:0];
        bus.dx       <= dx_new;
        bus.dy       <= dy_new;
        bus.cursor_x <= cx_new;
        bus.cursor_y <= cy_new;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed testbench for ps2_mouse_packet: a packet table plus hand-written
// sequences for misalignment, timeout, back-to-back strobes and reset mid-packet.
module tb_ps2_mouse_packet;

  localparam int T_OUT = 20;

  logic clk;
  logic rst_n;
  int   vec_count;
  int   miss_count;

  ps2_mouse_packet_if bus_if();

  ps2_mouse_packet #(.X_MAX(639), .Y_MAX(479), .TIMEOUT(T_OUT)) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .bus           (bus_if)
  );

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [9:0] cx;
    logic [8:0] cy;
  } vec_t;

  vec_t vecs[13];

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus_if.byte_valid = 1'b1;
    bus_if.byte_data  = b;
    @(negedge clk);
    bus_if.byte_valid = 1'b0;
    bus_if.byte_data  = 8'h00;
  endtask

  task automatic checkPacket(input string tag, input logic [2:0] btn, input logic [8:0] dx,
                             input logic [8:0] dy, input logic [9:0] cx, input logic [8:0] cy);
    checkOutput({tag, " buttons"},  {13'd0, bus_if.buttons},  {13'd0, btn});
    checkOutput({tag, " dx"},       {7'd0, bus_if.dx},        {7'd0, dx});
    checkOutput({tag, " dy"},       {7'd0, bus_if.dy},        {7'd0, dy});
    checkOutput({tag, " cursor_x"}, {6'd0, bus_if.cursor_x},  {6'd0, cx});
    checkOutput({tag, " cursor_y"}, {7'd0, bus_if.cursor_y},  {7'd0, cy});
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    send_byte(v.b0);
    checkOutput({tag, " pkt_valid after b0"}, {15'd0, bus_if.pkt_valid}, 16'd0);
    send_byte(v.b1);
    checkOutput({tag, " pkt_valid after b1"}, {15'd0, bus_if.pkt_valid}, 16'd0);
    send_byte(v.b2);
    checkOutput({tag, " pkt_valid after b2"}, {15'd0, bus_if.pkt_valid}, 16'd1);
    checkOutput({tag, " sync_err"},           {15'd0, bus_if.sync_err},  16'd0);
    checkPacket(tag, v.btn, v.dx, v.dy, v.cx, v.cy);
    @(negedge clk);
    checkOutput({tag, " pkt_valid single cycle"}, {15'd0, bus_if.pkt_valid}, 16'd0);
  endtask

  task automatic setVec(input int i, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [2:0] btn, input logic [8:0] dx, input logic [8:0] dy,
                        input logic [9:0] cx, input logic [8:0] cy);
    vecs[i].b0 = b0; vecs[i].b1 = b1; vecs[i].b2 = b2;
    vecs[i].btn = btn; vecs[i].dx = dx; vecs[i].dy = dy;
    vecs[i].cx = cx; vecs[i].cy = cy;
  endtask

  initial begin
    vec_t v;
    vec_count  = 0;
    miss_count = 0;
    bus_if.byte_valid = 1'b0;
    bus_if.byte_data  = 8'h00;

    // Each packet starts from the cursor left by the previous row
    setVec(0,  8'h09, 8'h05, 8'h03, 3'd1, 9'h005, 9'h003, 10'd324, 9'd236);
    setVec(1,  8'h38, 8'hFB, 8'hFE, 3'd0, 9'h1FB, 9'h1FE, 10'd319, 9'd238);
    setVec(2,  8'h18, 8'h01, 8'h00, 3'd0, 9'h101, 9'h000, 10'd64,  9'd238);
    setVec(3,  8'h18, 8'h01, 8'h00, 3'd0, 9'h101, 9'h000, 10'd0,   9'd238);
    setVec(4,  8'h08, 8'h00, 8'hFF, 3'd0, 9'h000, 9'h0FF, 10'd0,   9'd0);
    setVec(5,  8'h08, 8'hFF, 8'h00, 3'd0, 9'h0FF, 9'h000, 10'd255, 9'd0);
    setVec(6,  8'h08, 8'hFF, 8'h00, 3'd0, 9'h0FF, 9'h000, 10'd510, 9'd0);
    setVec(7,  8'h08, 8'hFF, 8'h00, 3'd0, 9'h0FF, 9'h000, 10'd639, 9'd0);
    setVec(8,  8'h28, 8'h00, 8'h80, 3'd0, 9'h000, 9'h180, 10'd639, 9'd128);
    setVec(9,  8'h2C, 8'h00, 8'h01, 3'd4, 9'h000, 9'h101, 10'd639, 9'd383);
    setVec(10, 8'h28, 8'h00, 8'h00, 3'd0, 9'h000, 9'h100, 10'd639, 9'd479);
    setVec(11, 8'h8F, 8'h10, 8'h55, 3'd7, 9'h010, 9'h000, 10'd639, 9'd479);
    setVec(12, 8'h48, 8'h7F, 8'h01, 3'd0, 9'h000, 9'h001, 10'd639, 9'd478);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset pkt_valid", {15'd0, bus_if.pkt_valid}, 16'd0);
    checkOutput("reset sync_err",  {15'd0, bus_if.sync_err},  16'd0);
    checkPacket("reset", 3'd0, 9'd0, 9'd0, 10'd319, 9'd239);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (i == 12) begin
        // A byte without the header marker is thrown away, and the outputs hold
        send_byte(8'h00);
        checkOutput("misalign sync_err",  {15'd0, bus_if.sync_err},  16'd1);
        checkOutput("misalign pkt_valid", {15'd0, bus_if.pkt_valid}, 16'd0);
        checkOutput("misalign dx hold",   {7'd0, bus_if.dx},         16'h0010);
        @(negedge clk);
        checkOutput("misalign sync_err pulse end", {15'd0, bus_if.sync_err}, 16'd0);
      end
      v = vecs[i];
      applyStimulus($sformatf("vec%0d", i), v);
    end

    // Partial packet left idle: it is dropped once the gap counter reaches T_OUT
    send_byte(8'h08);
    send_byte(8'h10);
    repeat (T_OUT) @(negedge clk);
    checkOutput("timeout early sync_err", {15'd0, bus_if.sync_err}, 16'd0);
    @(negedge clk);
    checkOutput("timeout sync_err",   {15'd0, bus_if.sync_err},  16'd1);
    checkOutput("timeout pkt_valid",  {15'd0, bus_if.pkt_valid}, 16'd0);
    checkOutput("timeout cy hold",    {7'd0, bus_if.cursor_y},   16'd478);
    @(negedge clk);
    checkOutput("timeout sync_err pulse end", {15'd0, bus_if.sync_err}, 16'd0);
    v = '{8'h08, 8'h02, 8'h00, 3'd0, 9'h002, 9'h000, 10'd639, 9'd478};
    applyStimulus("post-timeout", v);

    // Third byte lands on the expiry cycle: the byte wins
    send_byte(8'h18);
    send_byte(8'hE0);
    repeat (T_OUT - 1) @(negedge clk);
    send_byte(8'h00);
    checkOutput("expiry pkt_valid", {15'd0, bus_if.pkt_valid}, 16'd1);
    checkOutput("expiry sync_err",  {15'd0, bus_if.sync_err},  16'd0);
    checkPacket("expiry", 3'd0, 9'h1E0, 9'h000, 10'd607, 9'd478);
    @(negedge clk);
    checkOutput("expiry sync_err next", {15'd0, bus_if.sync_err}, 16'd0);

    // Strobes on three consecutive cycles
    @(negedge clk);
    bus_if.byte_valid = 1'b1;
    bus_if.byte_data  = 8'h09;
    @(negedge clk);
    bus_if.byte_data  = 8'h01;
    @(negedge clk);
    checkOutput("b2b pkt_valid early", {15'd0, bus_if.pkt_valid}, 16'd0);
    bus_if.byte_data  = 8'h01;
    @(negedge clk);
    bus_if.byte_valid = 1'b0;
    bus_if.byte_data  = 8'h00;
    checkOutput("b2b pkt_valid", {15'd0, bus_if.pkt_valid}, 16'd1);
    checkPacket("b2b", 3'd1, 9'h001, 9'h001, 10'd608, 9'd477);

    // Reset asserted in the middle of a packet
    send_byte(8'h08);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset pkt_valid", {15'd0, bus_if.pkt_valid}, 16'd0);
    checkOutput("midreset sync_err",  {15'd0, bus_if.sync_err},  16'd0);
    checkPacket("midreset", 3'd0, 9'd0, 9'd0, 10'd319, 9'd239);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{8'h08, 8'h00, 8'h00, 3'd0, 9'h000, 9'h000, 10'd319, 9'd239};
    applyStimulus("post-reset", v);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
